// File: rtl/vdp_port_pkg.sv
// Shared types and constants for the VDP CPU-port master: op codes, port numbers,
// control-byte prefixes, per-byte bus states and the command-to-byte expander.
package vdp_port_pkg;

    localparam int unsigned VPM_BYTES_MAX = 4;
    localparam int unsigned VPM_CNT_W     = 8;
    localparam int unsigned VPM_REG_W     = 6;
    localparam int unsigned VPM_ADDR_W    = 17;

    localparam logic [1:0] VDP_PORT_DATA = 2'd0;
    localparam logic [1:0] VDP_PORT_CTRL = 2'd1;
    localparam logic [1:0] VDP_PORT_PAL  = 2'd2;
    localparam logic [1:0] VDP_PORT_IND  = 2'd3;

    localparam logic [7:0] VDP_CTRL_REG_WR  = 8'h80;
    localparam logic [7:0] VDP_CTRL_VRAM_WR = 8'h40;
    localparam logic [7:0] VDP_REG_ADDR_HI  = 8'h0E;

    typedef enum logic [2:0] {
        VPM_WR_DATA   = 3'd0,
        VPM_RD_DATA   = 3'd1,
        VPM_WR_REG    = 3'd2,
        VPM_SET_WADDR = 3'd3,
        VPM_SET_RADDR = 3'd4,
        VPM_RD_STATUS = 3'd5,
        VPM_WR_PAL    = 3'd6,
        VPM_WR_IND    = 3'd7
    } vpm_op_e;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD,
        BUS_GAP
    } vpm_bus_state_e;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       rd;
    } vpm_byte_t;

    typedef struct packed {
        logic [2:0]                       cnt;
        vpm_byte_t [VPM_BYTES_MAX-1:0]    bytes;
    } vpm_list_t;

    function automatic vpm_byte_t vpm_mk(logic [1:0] port, logic [7:0] data, logic rd);
        vpm_byte_t b;
        b.port = port;
        b.data = data;
        b.rd   = rd;
        return b;
    endfunction

    // One command becomes 1-4 port bytes, issued from index 0 upward.
    function automatic vpm_list_t vpm_expand(vpm_op_e op, logic [VPM_REG_W-1:0] rg,
                                             logic [7:0] data, logic [VPM_ADDR_W-1:0] addr);
        vpm_list_t lst;
        lst     = '0;
        lst.cnt = 3'd1;
        case (op)
            VPM_WR_DATA:   lst.bytes[0] = vpm_mk(VDP_PORT_DATA, data, 1'b0);
            VPM_RD_DATA:   lst.bytes[0] = vpm_mk(VDP_PORT_DATA, 8'h00, 1'b1);
            VPM_WR_REG: begin
                lst.cnt      = 3'd2;
                lst.bytes[0] = vpm_mk(VDP_PORT_CTRL, data, 1'b0);
                lst.bytes[1] = vpm_mk(VDP_PORT_CTRL, VDP_CTRL_REG_WR | {2'b00, rg}, 1'b0);
            end
            VPM_SET_WADDR, VPM_SET_RADDR: begin
                lst.cnt      = 3'd4;
                lst.bytes[0] = vpm_mk(VDP_PORT_CTRL, {5'b00000, addr[16:14]}, 1'b0);
                lst.bytes[1] = vpm_mk(VDP_PORT_CTRL, VDP_CTRL_REG_WR | VDP_REG_ADDR_HI, 1'b0);
                lst.bytes[2] = vpm_mk(VDP_PORT_CTRL, addr[7:0], 1'b0);
                lst.bytes[3] = vpm_mk(VDP_PORT_CTRL,
                                      ((op == VPM_SET_WADDR) ? VDP_CTRL_VRAM_WR : 8'h00)
                                      | {2'b00, addr[13:8]}, 1'b0);
            end
            VPM_RD_STATUS: lst.bytes[0] = vpm_mk(VDP_PORT_CTRL, 8'h00, 1'b1);
            VPM_WR_PAL:    lst.bytes[0] = vpm_mk(VDP_PORT_PAL, data, 1'b0);
            VPM_WR_IND:    lst.bytes[0] = vpm_mk(VDP_PORT_IND, data, 1'b0);
        endcase
        return lst;
    endfunction

endpackage

// File: rtl/vdp_port_master_if.sv
// Command/response channel plus VDP CPU-port pins of the port master.
// master = the port master itself, slave = requester and VDP side.
interface vdp_port_master_if;
    import vdp_port_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [VPM_REG_W-1:0]  cmd_reg;
    logic [7:0]            cmd_data;
    logic [VPM_ADDR_W-1:0] cmd_addr;
    logic                  rsp_valid;
    logic [7:0]            rsp_data;
    logic                  busy;
    logic                  csw_n;
    logic                  csr_n;
    logic [1:0]            mode;
    logic [7:0]            cd_o;
    logic                  cd_oe;
    logic [7:0]            cd_i;

    modport master (
        input  cmd_valid, cmd_op, cmd_reg, cmd_data, cmd_addr, cd_i,
        output cmd_ready, rsp_valid, rsp_data, busy, csw_n, csr_n, mode, cd_o, cd_oe
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_reg, cmd_data, cmd_addr, cd_i,
        input  cmd_ready, rsp_valid, rsp_data, busy, csw_n, csr_n, mode, cd_o, cd_oe
    );

endinterface

// File: rtl/vdp_bus_cycle.sv
// Single-byte SETUP/STROBE/HOLD/GAP engine for the VDP CPU port.
// Read strobes and the cd_i capture exist only when VDP_PORT_MASTER_RD_EN is defined.
module vdp_bus_cycle
    import vdp_port_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic       clk_w,
    input  logic       reset_n_w,
    input  logic       start,
    input  vpm_byte_t  byte_in,
    output logic       done_c,
    output logic       csw_n,
    output logic       csr_n,
    output logic [1:0] mode,
    output logic [7:0] cd_o,
    output logic       cd_oe,
    input  logic [7:0] cd_i,
    output logic       rsp_valid,
    output logic [7:0] rsp_data
);

    vpm_bus_state_e       state;
    logic [VPM_CNT_W-1:0] cnt;
    logic                 rd_q;

    // A new byte may start in IDLE or in the final GAP cycle (back-to-back bytes).
    assign done_c = (state == BUS_IDLE) || ((state == BUS_GAP) && (cnt == '0));

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            state <= BUS_IDLE;
            cnt   <= '0;
            rd_q  <= 1'b0;
            csw_n <= 1'b1;
            mode  <= 2'd0;
            cd_o  <= 8'h00;
            cd_oe <= 1'b0;
        end else begin
            case (state)
                BUS_SETUP: begin
                    if (cnt == '0) begin
                        state <= BUS_STROBE;
                        cnt   <= VPM_CNT_W'(STROBE_CYC - 1);
                        csw_n <= rd_q;
                    end else begin
                        cnt <= cnt - VPM_CNT_W'(1);
                    end
                end
                BUS_STROBE: begin
                    if (cnt == '0) begin
                        state <= BUS_HOLD;
                        cnt   <= VPM_CNT_W'(HOLD_CYC - 1);
                        csw_n <= 1'b1;
                    end else begin
                        cnt <= cnt - VPM_CNT_W'(1);
                    end
                end
                BUS_HOLD: begin
                    if (cnt == '0) begin
                        state <= BUS_GAP;
                        cnt   <= VPM_CNT_W'(GAP_CYC - 1);
                        cd_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - VPM_CNT_W'(1);
                    end
                end
                BUS_GAP: begin
                    if (cnt == '0) begin
                        state <= BUS_IDLE;
                    end else begin
                        cnt <= cnt - VPM_CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (start && done_c) begin
                state <= BUS_SETUP;
                cnt   <= VPM_CNT_W'(SETUP_CYC - 1);
                rd_q  <= byte_in.rd;
                mode  <= byte_in.port;
                if (!byte_in.rd) begin
                    cd_o  <= byte_in.data;
                    cd_oe <= 1'b1;
                end
            end
        end
    end

`ifdef VDP_PORT_MASTER_RD_EN
    // Read strobe mirrors the write strobe; cd_i is taken in the last STROBE cycle.
    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            csr_n     <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            if ((state == BUS_SETUP) && (cnt == '0) && rd_q) begin
                csr_n <= 1'b0;
            end
            if ((state == BUS_STROBE) && (cnt == '0)) begin
                csr_n <= 1'b1;
                if (rd_q) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= cd_i;
                end
            end
        end
    end
`else
    logic [7:0] unused_cd_i;
    assign unused_cd_i = cd_i;
    assign csr_n       = 1'b1;
    assign rsp_valid   = 1'b0;
    assign rsp_data    = 8'h00;
`endif

endmodule

// File: rtl/vdp_port_master.sv
// Host-side VDP CPU-port initiator: expands one command into 1-4 timed port bytes.
// Reads are enabled by defining VDP_PORT_MASTER_RD_EN; otherwise read ops are dummy slots.
module vdp_port_master
    import vdp_port_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 6,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned GAP_CYC    = 2
) (
    input logic             clk_w,
    input logic             reset_n_w,
    vdp_port_master_if.master bus
);

    vpm_list_t list_c;
    vpm_list_t list_q;
    logic [2:0] idx_q;
    logic       rdy_q;
    logic       busy_q;
    logic       accept_c;
    logic       more_c;
    logic       done_c;
    logic       start_c;
    vpm_byte_t  byte_c;

    assign accept_c = bus.cmd_valid & rdy_q;
    assign list_c   = vpm_expand(vpm_op_e'(bus.cmd_op), bus.cmd_reg, bus.cmd_data, bus.cmd_addr);
    assign more_c   = ~rdy_q & (idx_q < list_q.cnt);

    // First byte goes straight from the accepted command; later ones from the stored list.
    always_comb begin
        start_c = 1'b0;
        byte_c  = list_q.bytes[idx_q[1:0]];
        if (accept_c) begin
            start_c = 1'b1;
            byte_c  = list_c.bytes[0];
        end else if (more_c) begin
            start_c = 1'b1;
        end
    end

    always_ff @(posedge clk_w or negedge reset_n_w) begin
        if (!reset_n_w) begin
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
            idx_q  <= 3'd0;
            list_q <= '0;
        end else if (accept_c) begin
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            list_q <= list_c;
            idx_q  <= 3'd1;
        end else if (!rdy_q && done_c) begin
            if (more_c) begin
                idx_q <= idx_q + 3'd1;
            end else begin
                rdy_q  <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = rdy_q;
    assign bus.busy      = busy_q;

    vdp_bus_cycle #(
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .GAP_CYC    (GAP_CYC)
    ) u_cycle (
        .clk_w     (clk_w),
        .reset_n_w (reset_n_w),
        .start     (start_c),
        .byte_in   (byte_c),
        .done_c    (done_c),
        .csw_n     (bus.csw_n),
        .csr_n     (bus.csr_n),
        .mode      (bus.mode),
        .cd_o      (bus.cd_o),
        .cd_oe     (bus.cd_oe),
        .cd_i      (bus.cd_i),
        .rsp_valid (bus.rsp_valid),
        .rsp_data  (bus.rsp_data)
    );

endmodule
